// File: rtl/muldiv_sequencer.sv
// HI/LO multiply/divide unit: shift-add multiply, restoring divide, MT/MF access and EX stall.
// Optional MULDIV_FAST_MUL_EN: MULT/MULTU use a single-cycle product in FIXUP instead of RUN.
module muldiv_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [5:0]        i_func,
  input  logic [DATA_W-1:0] i_op_a,
  input  logic [DATA_W-1:0] i_op_b,
  input  logic              i_flush,
  output logic              o_stall,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_div_zero,
  output logic [DATA_W-1:0] o_result,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;

  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MTLO = 6'b010011;

  function automatic logic [DATA_W-1:0] f_cneg(input logic [DATA_W-1:0] v, input logic en);
    f_cneg = en ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] f_cneg2(input logic [2*DATA_W-1:0] v, input logic en);
    f_cneg2 = en ? (~v + {{(2*DATA_W-1){1'b0}}, 1'b1}) : v;
  endfunction

  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*DATA_W-1:0] r_acc;
  logic [DATA_W-1:0]   r_opnd;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_is_div;
  logic                r_neg_res;
  logic                r_neg_rem;
  logic                r_div_zero;
  logic                r_done;
  logic                r_dz_out;

  logic                w_idle;
  logic                w_is_md;
  logic                w_is_hl;
  logic                w_div;
  logic                w_a_neg;
  logic                w_b_neg;
  logic                w_b_zero;
  logic [DATA_W-1:0]   w_mag_a;
  logic [DATA_W-1:0]   w_mag_b;
  logic                w_accept;
  logic                w_wr_hi;
  logic                w_wr_lo;
  logic [1:0]          w_first_state;
  logic [2*DATA_W-1:0] w_mag_prod;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W:0]     w_rem_sh;
  logic                w_rem_ge;
  logic [DATA_W-1:0]   w_rem_sub;
  logic [DATA_W-1:0]   w_addend;
  logic [DATA_W:0]     w_sum;
  logic [2*DATA_W-1:0] w_acc_next;
  logic [DATA_W-1:0]   w_hi_new;
  logic [DATA_W-1:0]   w_lo_new;

  // Opcode decode: 0110xx is mult/div (bit0 = unsigned, bit1 = divide), 0100xx is MT/MF.
  assign w_idle   = (r_state == S_IDLE);
  assign w_is_md  = (i_func[5:2] == 4'b0110);
  assign w_is_hl  = (i_func[5:2] == 4'b0100);
  assign w_div    = i_func[1];
  assign w_a_neg  = ~i_func[0] & i_op_a[DATA_W-1];
  assign w_b_neg  = ~i_func[0] & i_op_b[DATA_W-1];
  assign w_b_zero = (i_op_b == {DATA_W{1'b0}});
  assign w_mag_a  = f_cneg(i_op_a, w_a_neg);
  assign w_mag_b  = f_cneg(i_op_b, w_b_neg);

  assign w_accept = i_start & w_is_md & w_idle & ~i_flush;
  assign w_wr_hi  = i_start & w_idle & ~i_flush & (i_func == F_MTHI);
  assign w_wr_lo  = i_start & w_idle & ~i_flush & (i_func == F_MTLO);

  assign o_busy  = ~w_idle;
  assign o_stall = i_start & o_busy & (w_is_md | w_is_hl);
  assign o_done     = r_done;
  assign o_div_zero = r_dz_out;
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;

`ifdef MULDIV_FAST_MUL_EN
  assign w_first_state = w_div ? S_RUN : S_FIXUP;
  assign w_mag_prod    = {{DATA_W{1'b0}}, r_opnd} * {{DATA_W{1'b0}}, r_acc[DATA_W-1:0]};
`else
  assign w_first_state = S_RUN;
  assign w_mag_prod    = r_acc;
`endif

  // Divide keeps {remainder, quotient} in r_acc; the partial remainder always stays below the divisor.
  assign w_rem_sh  = r_acc[2*DATA_W-1:DATA_W-1];
  assign w_rem_ge  = (w_rem_sh >= {1'b0, r_opnd});
  assign w_rem_sub = w_rem_sh[DATA_W-1:0] - r_opnd;
  assign w_addend  = r_acc[0] ? r_opnd : {DATA_W{1'b0}};
  assign w_sum     = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, w_addend};

  // One engine iteration: restoring-divide step or shift-add multiply step.
  always_comb begin
    w_acc_next = r_acc;
    if (r_is_div) begin
      if (w_rem_ge) begin
        w_acc_next = {w_rem_sub, r_acc[DATA_W-2:0], 1'b1};
      end else begin
        w_acc_next = {w_rem_sh[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0};
      end
    end else begin
      w_acc_next = {w_sum, r_acc[DATA_W-1:1]};
    end
  end

  // Sign fixup; on divide-by-zero r_opnd holds the raw dividend so HI returns it untouched.
  always_comb begin
    w_prod   = f_cneg2(w_mag_prod, r_neg_res);
    w_hi_new = w_prod[2*DATA_W-1:DATA_W];
    w_lo_new = w_prod[DATA_W-1:0];
    if (r_is_div) begin
      if (r_div_zero) begin
        w_hi_new = r_opnd;
        w_lo_new = {DATA_W{1'b1}};
      end else begin
        w_hi_new = f_cneg(r_acc[2*DATA_W-1:DATA_W], r_neg_rem);
        w_lo_new = f_cneg(r_acc[DATA_W-1:0], r_neg_res);
      end
    end else begin
      w_hi_new = w_prod[2*DATA_W-1:DATA_W];
      w_lo_new = w_prod[DATA_W-1:0];
    end
  end

  // MF read port: only driven while an MF instruction is presented.
  always_comb begin
    o_result = {DATA_W{1'b0}};
    if (i_start && (i_func == F_MFHI)) begin
      o_result = r_hi;
    end else if (i_start && (i_func == F_MFLO)) begin
      o_result = r_lo;
    end else begin
      o_result = {DATA_W{1'b0}};
    end
  end

  // Sequencer, engine registers and HI/LO.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= {CNT_W{1'b0}};
      r_acc      <= {(2*DATA_W){1'b0}};
      r_opnd     <= {DATA_W{1'b0}};
      r_hi       <= {DATA_W{1'b0}};
      r_lo       <= {DATA_W{1'b0}};
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_div_zero <= 1'b0;
      r_done     <= 1'b0;
      r_dz_out   <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_dz_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state    <= w_first_state;
            r_cnt      <= CNT_W'(DATA_W - 1);
            r_is_div   <= w_div;
            r_neg_res  <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg;
            r_div_zero <= w_div & w_b_zero;
            if (w_div) begin
              r_acc  <= {{DATA_W{1'b0}}, w_mag_a};
              r_opnd <= w_b_zero ? i_op_a : w_mag_b;
            end else begin
              r_acc  <= {{DATA_W{1'b0}}, w_mag_b};
              r_opnd <= w_mag_a;
            end
          end
          if (w_wr_hi) begin
            r_hi <= i_op_a;
          end
          if (w_wr_lo) begin
            r_lo <= i_op_a;
          end
        end
        S_RUN: begin
          if (i_flush) begin
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_acc_next;
            if (r_cnt == {CNT_W{1'b0}}) begin
              r_state <= S_FIXUP;
            end else begin
              r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        S_FIXUP: begin
          r_state <= S_IDLE;
          if (!i_flush) begin
            r_hi     <= w_hi_new;
            r_lo     <= w_lo_new;
            r_done   <= 1'b1;
            r_dz_out <= r_div_zero;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: arithmetic reference model, decoupled done monitor.
module tb_muldiv_sequencer;

  localparam int DW      = 32;
  localparam int LAT_DIV = DW + 2;
`ifdef MULDIV_FAST_MUL_EN
  localparam int LAT_MUL = 2;
`else
  localparam int LAT_MUL = DW + 2;
`endif

  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] MTLO  = 6'b010011;

  logic          clk;
  logic          rst;
  logic          start;
  logic [5:0]    func;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          flush;
  logic          stall;
  logic          busy;
  logic          done;
  logic          div_zero;
  logic [DW-1:0] result;
  logic [DW-1:0] hi;
  logic [DW-1:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_checks;
  int   n_pass;

  muldiv_sequencer dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_func(func),
    .i_op_a(op_a), .i_op_b(op_b), .i_flush(flush),
    .o_stall(stall), .o_busy(busy), .o_done(done), .o_div_zero(div_zero),
    .o_result(result), .o_hi(hi), .o_lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] mhi, output logic [31:0] mlo, output logic mdz);
    longint sa;
    longint sbv;
    longint p;
    int     q;
    int     r;
    mdz = 1'b0;
    mhi = 32'd0;
    mlo = 32'd0;
    sa  = $signed(a);
    sbv = $signed(b);
    case (f)
      MULT: begin
        p = sa * sbv;
        {mhi, mlo} = p;
      end
      MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        {mhi, mlo} = p;
      end
      DIV, DIVU: begin
        if (b == 32'd0) begin
          mlo = 32'hFFFF_FFFF;
          mhi = a;
          mdz = 1'b1;
        end else if (f == DIVU) begin
          mlo = a / b;
          mhi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          mlo = 32'h8000_0000;
          mhi = 32'd0;
        end else begin
          q = int'(sa) / int'(sbv);
          r = int'(sa) % int'(sbv);
          mlo = q;
          mhi = r;
        end
      end
      default: begin
        mhi = 32'd0;
        mlo = 32'd0;
      end
    endcase
  endtask

  // Monitor: every done pulse must match the oldest expectation, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {63'd0, done}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("hi", {32'd0, hi}, {32'd0, e.hi});
        chk("lo", {32'd0, lo}, {32'd0, e.lo});
        chk("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else if (div_zero) begin
      chk("dz_without_done", {63'd0, div_zero}, 64'd0);
    end
  end

  task automatic push_exp(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    model(f, a, b, e.hi, e.lo, e.dz);
    e.cyc = cyc + (f[1] ? LAT_DIV : LAT_MUL);
    sb.push_back(e);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() > 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() > 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    push_exp(f, a, b);
    start = 1'b1; func = f; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    drain();
  endtask

  task automatic mt(input logic [5:0] f, input logic [31:0] v);
    start = 1'b1; func = f; op_a = v;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Start a DIVU 100/7 and inject flush or reset during cycle 10.
  task automatic abort_at_10(input logic use_rst);
    start = 1'b1; func = DIVU; op_a = 32'd100; op_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    @(negedge clk);
    chk("busy_before_abort", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("busy_after_abort", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [5:0]  rf;
    logic [31:0] ra;
    logic [31:0] rb;
    n_checks = 0; n_pass = 0;
    rst = 1'b1; start = 1'b0; func = 6'd0; op_a = 32'd0; op_b = 32'd0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    @(posedge clk); #1;

    run_md(MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    chk("tp_mult_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
    chk("tp_mult_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFE);
    run_md(MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    chk("tp_multu_hi", {32'd0, hi}, 64'h0000_0000_0000_0001);
    chk("tp_multu_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFE);
    run_md(DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    chk("tp_div_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
    chk("tp_div_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
    run_md(DIVU, 32'd7, 32'd0);
    chk("tp_divz_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFF);
    chk("tp_divz_hi", {32'd0, hi}, 64'd7);
    run_md(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("tp_ovf_lo", {32'd0, lo}, 64'h0000_0000_8000_0000);
    chk("tp_ovf_hi", {32'd0, hi}, 64'd0);
    run_md(DIV, 32'hFFFF_FFF9, 32'd0);

    // MFLO held behind a MULTU: stalled until the done cycle, which already reads the new LO.
    push_exp(MULTU, 32'd3, 32'd5);
    start = 1'b1; func = MULTU; op_a = 32'd3; op_b = 32'd5;
    @(posedge clk); #1;
    func = MFLO;
    for (int n = 1; n <= LAT_MUL; n++) begin
      @(negedge clk);
      chk("mflo_stall", {63'd0, stall}, {63'd0, (n < LAT_MUL)});
      if (n == LAT_MUL) chk("mflo_result", {32'd0, result}, 64'h0000_0000_0000_000F);
      @(posedge clk); #1;
    end
    start = 1'b0;
    drain();

    start = 1'b1; func = MTHI; op_a = 32'h1234_5678;
    @(negedge clk);
    chk("mthi_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    func = MFHI;
    @(negedge clk);
    chk("mfhi_stall", {63'd0, stall}, 64'd0);
    chk("mfhi_result", {32'd0, result}, 64'h0000_0000_1234_5678);
    @(posedge clk); #1;
    func = MTLO; op_a = 32'hCAFE_0001;
    @(posedge clk); #1;
    func = MFLO;
    @(negedge clk);
    chk("mflo_after_mt", {32'd0, result}, 64'h0000_0000_CAFE_0001);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("result_idle_zero", {32'd0, result}, 64'd0);
    @(posedge clk); #1;

    mt(MTHI, 32'hAAAA_5555);
    mt(MTLO, 32'h1234_ABCD);
    abort_at_10(1'b0);
    chk("flush_hi_kept", {32'd0, hi}, 64'h0000_0000_AAAA_5555);
    chk("flush_lo_kept", {32'd0, lo}, 64'h0000_0000_1234_ABCD);
    repeat (40) @(posedge clk);
    #1;
    abort_at_10(1'b1);
    chk("rst_mid_hi", {32'd0, hi}, 64'd0);
    chk("rst_mid_lo", {32'd0, lo}, 64'd0);
    repeat (40) @(posedge clk);
    #1;

    start = 1'b1; func = 6'b100000; op_a = 32'hFFFF_FFFF; op_b = 32'd1;
    @(negedge clk);
    chk("unk_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("unk_busy", {63'd0, busy}, 64'd0);
    chk("unk_hi", {32'd0, hi}, 64'd0);
    @(posedge clk); #1;

    start = 1'b1; func = MULT; op_a = 32'd9; op_b = 32'd9; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_start_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(posedge clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      rf = {4'b0110, 2'($urandom_range(0, 3))};
      ra = $urandom;
      rb = $urandom;
      if (i % 8 == 3) rb = 32'd0;
      if (i % 8 == 5) rb = $urandom_range(1, 15);
      if (i % 8 == 6) ra = $urandom_range(0, 255);
      if (i % 8 == 7) rb = 32'hFFFF_FFFF;
      run_md(rf, ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
